// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Sequences the multi-cycle HI/LO multiply unit in the EX stage. The unit
// multiplies iteratively with shift-add and can accumulate or subtract the
// product into HI/LO. It owns the HI/LO registers and raises stall_o for
// interlocks: mfhi/mflo, back-to-back MD ops and a blocking mul.
//
// Parameter:
//   BITS_PER_CYCLE  multiplier bits retired per CALC cycle (1, 2 or 4)
//
// Optional feature macro: MDU_EARLY_OUT_EN
//   defined   : CALC ends as soon as the remaining multiplier is zero
//   undefined : CALC always takes 32/BITS_PER_CYCLE cycles
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   ex_valid_i         valid instruction in EX
//   ex_advance_i       EX moves to MEM this cycle
//   flush_i            squash EX instruction
//   sign_i, we_i, en_c_i, add_sub_i, hilo_i[1:0], mul_i  decoded MD controls
//   rs_data_i, rt_data_i  operands A (multiplicand) / B (multiplier)
//   hi_o, lo_o         HI/LO registers
//   mf_data_o          hi_o when hilo_i=10, else lo_o (combinational)
//   mul_result_o       low product word for mul
//   mul_valid_o        mul_result_o valid (WB of a mul)
//   stall_o            hold IF/ID/EX
//   busy_o             sequencer not idle
module mdu_sequencer #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        ex_advance_i,
  input  logic        flush_i,
  input  logic        sign_i,
  input  logic        we_i,
  input  logic        en_c_i,
  input  logic        add_sub_i,
  input  logic [1:0]  hilo_i,
  input  logic        mul_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data_o,
  output logic [31:0] mul_result_o,
  output logic        mul_valid_o,
  output logic        stall_o,
  output logic        busy_o
);

  localparam int N_ITER = 32 / BITS_PER_CYCLE;
  localparam int CW     = $clog2(N_ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        neg_q, neg_d, en_c_q, en_c_d, add_sub_q, add_sub_d, mul_q, mul_d;

  logic        md_op, mt_op, mf_op, busy, own_wb;
  logic [31:0] rs_mag, rt_mag, mplier_shift;
  logic [63:0] step_sum, hilo_new;
  logic        calc_done;

  assign md_op = we_i & (hilo_i == 2'b11);
  assign mt_op = we_i & ((hilo_i == 2'b10) | (hilo_i == 2'b01));
  assign mf_op = ~we_i & (hilo_i != 2'b00);
  assign busy  = (state_q != S_IDLE);
  // The mul sitting in EX during its own WB is the result consumer, not a
  // new MD op, so it must not stall against itself.
  assign own_wb = (state_q == S_WB) & mul_q;

  assign stall_o = ex_valid_i & ~flush_i &
                   (mul_i ? ~own_wb : ((mf_op | md_op | mt_op) & busy));

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign rs_mag = (sign_i & rs_data_i[31]) ? (~rs_data_i + 32'd1) : rs_data_i;
  assign rt_mag = (sign_i & rt_data_i[31]) ? (~rt_data_i + 32'd1) : rt_data_i;

  assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

  always_comb begin
    step_sum = prod_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
    end
  end

`ifdef MDU_EARLY_OUT_EN
  assign calc_done = (cnt_q == '0) | (mplier_shift == 32'd0);
`else
  assign calc_done = (cnt_q == '0);
`endif

  assign hilo_new = en_c_q ? (add_sub_q ? ({hi_q, lo_q} - prod_q)
                                        : ({hi_q, lo_q} + prod_q))
                           : prod_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    en_c_d    = en_c_q;
    add_sub_d = add_sub_q;
    mul_d     = mul_q;
    // A flushed mul is still in EX, so it can be dropped without any write.
    // Non-mul ops have already left EX and always complete.
    if (busy & mul_q & flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ex_valid_i & ~flush_i) begin
            if (md_op) begin
              mcand_d   = {32'd0, rs_mag};
              mplier_d  = rt_mag;
              prod_d    = 64'd0;
              cnt_d     = CW'(N_ITER - 1);
              neg_d     = sign_i & (rs_data_i[31] ^ rt_data_i[31]);
              en_c_d    = en_c_i;
              add_sub_d = add_sub_i;
              mul_d     = mul_i;
              state_d   = S_CALC;
            end else if (mt_op) begin
              if (hilo_i == 2'b10) hi_d = rs_data_i;
              else                 lo_d = rs_data_i;
            end
          end
        end
        S_CALC: begin
          prod_d   = step_sum;
          mplier_d = mplier_shift;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          cnt_d    = cnt_q - 1'b1;
          if (calc_done) state_d = S_FIX;
        end
        S_FIX: begin
          prod_d  = neg_q ? (~prod_q + 64'd1) : prod_q;
          state_d = S_WB;
        end
        S_WB: begin
          // mul holds WB (and its result) until the pipeline takes it.
          if (~mul_q | ex_advance_i) begin
            {hi_d, lo_d} = hilo_new;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      prod_q    <= 64'd0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      en_c_q    <= 1'b0;
      add_sub_q <= 1'b0;
      mul_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      en_c_q    <= en_c_d;
      add_sub_q <= add_sub_d;
      mul_q     <= mul_d;
    end
  end

  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign mf_data_o    = (hilo_i == 2'b10) ? hi_q : lo_q;
  assign mul_result_o = prod_q[31:0];
  assign mul_valid_o  = own_wb;
  assign busy_o       = busy;

endmodule
